// File: rtl/opcode_exec_stage.sv
// Accumulator execute stage: nop/add/sub on a WIDTH-bit accumulator behind a
// single-entry registered output with valid/ready handshakes on both sides,
// plus a sticky error flag and saturating debug counters.
module opcode_exec_stage #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [4:0]           in_opcode,
    input  logic [WIDTH-1:0]     in_operand,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_acc,
    output logic [4:0]           out_opcode,
    output logic                 out_carry,
    output logic                 out_invalid,
    output logic                 err_sticky,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [CNT_WIDTH-1:0] invalid_count
);

    typedef enum logic [4:0] {
        OP_NOP = 5'd0,
        OP_ADD = 5'd1,
        OP_SUB = 5'd2
    } opcode_e;

    logic                 accept;
    logic                 consume;
    logic [WIDTH:0]       sum_w;
    logic [WIDTH:0]       diff_w;

    logic [WIDTH-1:0]     acc_q,       acc_d;
    logic [4:0]           opcode_q,    opcode_d;
    logic                 carry_q,     carry_d;
    logic                 invalid_q,   invalid_d;
    logic                 valid_q,     valid_d;
    logic                 err_q,       err_d;
    logic [CNT_WIDTH-1:0] icnt_q,      icnt_d;
    logic [CNT_WIDTH-1:0] vcnt_q,      vcnt_d;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign consume  = valid_q && out_ready;

    // Next-state: execute the offered instruction, commit only on accept
    always_comb begin
        sum_w     = {1'b0, acc_q} + {1'b0, in_operand};
        diff_w    = {1'b0, acc_q} - {1'b0, in_operand};
        acc_d     = acc_q;
        opcode_d  = opcode_q;
        carry_d   = carry_q;
        invalid_d = invalid_q;
        valid_d   = valid_q;
        err_d     = err_q;
        icnt_d    = icnt_q;
        vcnt_d    = vcnt_q;
        if (accept) begin
            opcode_d  = in_opcode;
            valid_d   = 1'b1;
            carry_d   = 1'b0;
            invalid_d = 1'b0;
            if (icnt_q != '1) icnt_d = icnt_q + CNT_WIDTH'(1);
            case (opcode_e'(in_opcode))
                OP_NOP: ;
                OP_ADD: begin
                    acc_d   = sum_w[WIDTH-1:0];
                    carry_d = sum_w[WIDTH];
                end
                OP_SUB: begin
                    // MSB of the zero-extended difference is the borrow
                    acc_d   = diff_w[WIDTH-1:0];
                    carry_d = diff_w[WIDTH];
                end
                default: begin
                    invalid_d = 1'b1;
                    err_d     = 1'b1;
                    if (vcnt_q != '1) vcnt_d = vcnt_q + CNT_WIDTH'(1);
                end
            endcase
        end else if (consume) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            acc_q     <= '0;
            opcode_q  <= '0;
            carry_q   <= 1'b0;
            invalid_q <= 1'b0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            icnt_q    <= '0;
            vcnt_q    <= '0;
        end else begin
            acc_q     <= acc_d;
            opcode_q  <= opcode_d;
            carry_q   <= carry_d;
            invalid_q <= invalid_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            icnt_q    <= icnt_d;
            vcnt_q    <= vcnt_d;
        end
    end

    assign out_acc       = acc_q;
    assign out_opcode    = opcode_q;
    assign out_carry     = carry_q;
    assign out_invalid   = invalid_q;
    assign out_valid     = valid_q;
    assign err_sticky    = err_q;
    assign instr_count   = icnt_q;
    assign invalid_count = vcnt_q;

endmodule

// File: tb/tb_opcode_exec_stage.sv
// Self-checking bench for opcode_exec_stage: directed vector table,
// handshake/reset corner sequences, counter saturation on a narrow-counter
// instance, and a randomized run against an arithmetic reference model.
module tb_opcode_exec_stage;

    logic        clock = 1'b0;
    logic        rst_n, iv, ir, ov, ordy, oc, oinv, err;
    logic [4:0]  iop, oop;
    logic [7:0]  iopnd, oacc;
    logic [15:0] icnt, vcnt;

    logic        b_rst_n, b_iv, b_ir, b_ov, b_ordy, b_oc, b_oinv, b_err;
    logic [4:0]  b_iop, b_oop;
    logic [7:0]  b_iopnd, b_oacc;
    logic [1:0]  b_icnt, b_vcnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    opcode_exec_stage #(.WIDTH(8), .CNT_WIDTH(16)) dut (
        .clock(clock), .reset_n(rst_n), .in_valid(iv), .in_ready(ir),
        .in_opcode(iop), .in_operand(iopnd), .out_valid(ov), .out_ready(ordy),
        .out_acc(oacc), .out_opcode(oop), .out_carry(oc), .out_invalid(oinv),
        .err_sticky(err), .instr_count(icnt), .invalid_count(vcnt)
    );

    opcode_exec_stage #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .clock(clock), .reset_n(b_rst_n), .in_valid(b_iv), .in_ready(b_ir),
        .in_opcode(b_iop), .in_operand(b_iopnd), .out_valid(b_ov), .out_ready(b_ordy),
        .out_acc(b_oacc), .out_opcode(b_oop), .out_carry(b_oc), .out_invalid(b_oinv),
        .err_sticky(b_err), .instr_count(b_icnt), .invalid_count(b_vcnt)
    );

    typedef struct {
        logic       vld;
        logic [4:0] op;
        logic [7:0] opnd;
        logic       e_ov;
        logic [7:0] e_acc;
        logic [4:0] e_op;
        logic       e_c;
        logic       e_inv;
        logic       e_err;
        int         e_icnt;
        int         e_vcnt;
    } vec_t;

    vec_t tbl[9];

    // reference model state
    int m_acc, m_op, m_c, m_inv, m_ov, m_err, m_icnt, m_vcnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic model_edge(input logic rst, input logic vld, input int op,
                              input int opnd, input logic rdy);
        int s;
        if (!rst) begin
            m_acc = 0; m_op = 0; m_c = 0; m_inv = 0; m_ov = 0;
            m_err = 0; m_icnt = 0; m_vcnt = 0;
        end else if (vld && (!m_ov || rdy)) begin
            m_c = 0; m_inv = 0; m_op = op; m_ov = 1;
            if (op == 1) begin
                s = m_acc + opnd;
                m_c = (s > 255) ? 1 : 0;
                m_acc = s % 256;
            end else if (op == 2) begin
                m_c = (opnd > m_acc) ? 1 : 0;
                m_acc = (m_acc - opnd + 256) % 256;
            end else if (op != 0) begin
                m_inv = 1; m_err = 1;
                m_vcnt = (m_vcnt < 65535) ? m_vcnt + 1 : 65535;
            end
            m_icnt = (m_icnt < 65535) ? m_icnt + 1 : 65535;
        end else if (m_ov && rdy) begin
            m_ov = 0;
        end
    endtask

    initial begin
        logic r_rst, r_vld, r_rdy;
        int   r_op, r_opnd;

        //             vld  op     opnd    ov    acc     op     c     inv   err  icnt vcnt
        tbl[0] = '{1'b1, 5'd1, 8'd5,   1'b1, 8'd5,   5'd1, 1'b0, 1'b0, 1'b0, 1, 0};
        tbl[1] = '{1'b1, 5'd1, 8'd7,   1'b1, 8'd12,  5'd1, 1'b0, 1'b0, 1'b0, 2, 0};
        tbl[2] = '{1'b1, 5'd2, 8'd3,   1'b1, 8'd9,   5'd2, 1'b0, 1'b0, 1'b0, 3, 0};
        tbl[3] = '{1'b1, 5'd1, 8'd241, 1'b1, 8'd250, 5'd1, 1'b0, 1'b0, 1'b0, 4, 0};
        tbl[4] = '{1'b1, 5'd1, 8'd10,  1'b1, 8'd4,   5'd1, 1'b1, 1'b0, 1'b0, 5, 0};
        tbl[5] = '{1'b1, 5'd2, 8'd5,   1'b1, 8'd255, 5'd2, 1'b1, 1'b0, 1'b0, 6, 0};
        tbl[6] = '{1'b1, 5'd7, 8'd99,  1'b1, 8'd255, 5'd7, 1'b0, 1'b1, 1'b1, 7, 1};
        tbl[7] = '{1'b1, 5'd0, 8'd0,   1'b1, 8'd255, 5'd0, 1'b0, 1'b0, 1'b1, 8, 1};
        tbl[8] = '{1'b0, 5'd1, 8'd77,  1'b0, 8'd255, 5'd0, 1'b0, 1'b0, 1'b1, 8, 1};

        rst_n = 1'b0; iv = 1'b0; iop = '0; iopnd = '0; ordy = 1'b1;
        b_rst_n = 1'b0; b_iv = 1'b0; b_iop = '0; b_iopnd = '0; b_ordy = 1'b1;
        tick(); tick();

        // reset state
        chk("rst_out_valid", 32'(ov), 32'd0);
        chk("rst_out_acc",   32'(oacc), 32'd0);
        chk("rst_carry",     32'(oc), 32'd0);
        chk("rst_invalid",   32'(oinv), 32'd0);
        chk("rst_err",       32'(err), 32'd0);
        chk("rst_icnt",      32'(icnt), 32'd0);
        chk("rst_vcnt",      32'(vcnt), 32'd0);
        chk("rst_in_ready",  32'(ir), 32'd1);
        rst_n = 1'b1;

        // directed vector table, out_ready held high
        for (int i = 0; i < 9; i++) begin
            iv = tbl[i].vld; iop = tbl[i].op; iopnd = tbl[i].opnd; ordy = 1'b1;
            #1 chk("tbl_in_ready", 32'(ir), 32'd1);
            tick();
            chk("tbl_out_valid", 32'(ov),   32'(tbl[i].e_ov));
            chk("tbl_out_acc",   32'(oacc), 32'(tbl[i].e_acc));
            chk("tbl_out_op",    32'(oop),  32'(tbl[i].e_op));
            chk("tbl_carry",     32'(oc),   32'(tbl[i].e_c));
            chk("tbl_invalid",   32'(oinv), 32'(tbl[i].e_inv));
            chk("tbl_err",       32'(err),  32'(tbl[i].e_err));
            chk("tbl_icnt",      32'(icnt), 32'(tbl[i].e_icnt));
            chk("tbl_vcnt",      32'(vcnt), 32'(tbl[i].e_vcnt));
        end

        // backpressure: one add, then 4 stalled cycles with a different instruction offered
        iv = 1'b1; iop = 5'd1; iopnd = 8'd1; ordy = 1'b1;
        tick();
        chk("bp_first_acc",   32'(oacc), 32'd0);
        chk("bp_first_carry", 32'(oc), 32'd1);
        iopnd = 8'd50; ordy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("bp_in_ready", 32'(ir), 32'd0);
            tick();
            chk("bp_hold_valid", 32'(ov), 32'd1);
            chk("bp_hold_acc",   32'(oacc), 32'd0);
            chk("bp_hold_carry", 32'(oc), 32'd1);
            chk("bp_hold_icnt",  32'(icnt), 32'd9);
        end
        iopnd = 8'd2; ordy = 1'b1;
        #1 chk("bp_release_ready", 32'(ir), 32'd1);
        tick();
        chk("bp_release_valid", 32'(ov), 32'd1);
        chk("bp_release_acc",   32'(oacc), 32'd2);
        chk("bp_release_icnt",  32'(icnt), 32'd10);
        iopnd = 8'd3;
        tick();
        chk("bp_next_acc",  32'(oacc), 32'd5);
        chk("bp_next_icnt", 32'(icnt), 32'd11);

        // reset while a beat is stalled
        iv = 1'b0; ordy = 1'b0;
        tick();
        chk("pre_rst_valid", 32'(ov), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mid_rst_valid", 32'(ov), 32'd0);
        chk("mid_rst_acc",   32'(oacc), 32'd0);
        chk("mid_rst_err",   32'(err), 32'd0);
        chk("mid_rst_icnt",  32'(icnt), 32'd0);
        chk("mid_rst_vcnt",  32'(vcnt), 32'd0);
        rst_n = 1'b1;

        // counter saturation on the 2-bit-counter instance
        b_rst_n = 1'b1; b_ordy = 1'b1; b_iv = 1'b1;
        b_iop = 5'd0;
        for (int i = 0; i < 3; i++) tick();
        b_iop = 5'd9;
        for (int i = 0; i < 2; i++) tick();
        chk("sat_icnt_pinned", 32'(b_icnt), 32'd3);
        chk("sat_vcnt_indep",  32'(b_vcnt), 32'd2);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_icnt_final", 32'(b_icnt), 32'd3);
        chk("sat_vcnt_final", 32'(b_vcnt), 32'd3);
        chk("sat_err",        32'(b_err), 32'd1);
        chk("sat_invalid",    32'(b_oinv), 32'd1);
        b_rst_n = 1'b0; b_iv = 1'b0;
        tick();
        chk("sat_rst_icnt", 32'(b_icnt), 32'd0);

        // randomized run against the reference model
        model_edge(1'b0, 1'b0, 0, 0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            r_rst  = ($urandom_range(0, 79) != 0);
            r_vld  = ($urandom_range(0, 3) != 0);
            r_rdy  = ($urandom_range(0, 2) != 0);
            r_op   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(3, 31))
                                                 : int'($urandom_range(0, 2));
            r_opnd = int'($urandom_range(0, 255));
            rst_n = r_rst; iv = r_vld; iop = 5'(r_op); iopnd = 8'(r_opnd); ordy = r_rdy;
            #1 chk("rnd_in_ready", 32'(ir), 32'((m_ov == 0) || r_rdy));
            tick();
            model_edge(r_rst, r_vld, r_op, r_opnd, r_rdy);
            chk("rnd_out_valid", 32'(ov),   32'(m_ov));
            chk("rnd_out_acc",   32'(oacc), 32'(m_acc));
            chk("rnd_out_op",    32'(oop),  32'(m_op));
            chk("rnd_carry",     32'(oc),   32'(m_c));
            chk("rnd_invalid",   32'(oinv), 32'(m_inv));
            chk("rnd_err",       32'(err),  32'(m_err));
            chk("rnd_icnt",      32'(icnt), 32'(m_icnt));
            chk("rnd_vcnt",      32'(vcnt), 32'(m_vcnt));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/opcode_exec_stage.md
Name: opcode_exec_stage

Overview:
- Accumulator execute stage that sits directly downstream of the 5-bit opcode decoder.
- Executes nop / add / sub against a WIDTH-bit accumulator and flags invalid opcodes.
- Consumes a valid/ready instruction stream (opcode + operand) and emits one registered result beat per accepted instruction.
- Keeps a sticky error flag and saturating instruction and invalid-opcode counters for debug.

Parameters:
- WIDTH, 8, operand/accumulator width in bits (≥2).
- CNT_WIDTH, 16, width of the instruction and invalid counters.

Ports:
- clock  input  1  sole clock; all state updates on the rising edge.
- reset_n  input  1  synchronous, active-low reset.
- in_valid  input  1  instruction present.
- in_ready  output  1  stage can accept an instruction this cycle.
- in_opcode  input  5  0=nop, 1=add, 2=sub, 3..31=invalid.
- in_operand  input  WIDTH  operand for add/sub; ignored otherwise.
- out_valid  output  1  result beat present.
- out_ready  input  1  downstream accepts the result beat.
- out_acc  output  WIDTH  accumulator value after the executed instruction.
- out_opcode  output  5  echo of the executed opcode.
- out_carry  output  1  add carry-out / sub borrow; 0 for nop and invalid.
- out_invalid  output  1  executed opcode was invalid.
- err_sticky  output  1  set by any accepted invalid opcode; cleared only by reset.
- instr_count  output  CNT_WIDTH  accepted instructions, saturating.
- invalid_count  output  CNT_WIDTH  accepted invalid opcodes, saturating.

Behaviour:
- Reset (reset_n=0 at a clock edge):
  - acc, out_acc, out_opcode, out_carry, out_invalid, out_valid, err_sticky and both counters go to 0.
  - Reset takes priority over all other activity. An in-flight output beat is dropped, not delivered.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational; single-entry output register).
  - An instruction is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
  - Accept and consume in the same cycle are legal, giving full throughput of 1 instruction per cycle.
  - Latency is 1 cycle: an instruction accepted at edge N has its result visible from edge N onward (out_valid=1 after edge N).
- Execution on accept:
  - nop: acc unchanged; carry=0; invalid=0.
  - add: {carry, acc} = acc + in_operand, computed at WIDTH+1 bits. acc wraps modulo 2^WIDTH.
  - sub: acc = acc - in_operand modulo 2^WIDTH; carry = 1 when in_operand > acc (borrow).
  - invalid: acc unchanged; carry=0; invalid=1; err_sticky is set; invalid_count increments.
  - Every accepted instruction increments instr_count.
  - The output register loads the new acc, opcode, carry and invalid flag; out_valid is set to 1.
- Idle output:
  - If a beat is consumed with no new accept, out_valid goes to 0.
  - out_acc, out_opcode and out_carry hold their last values.
- Backpressure:
  - While out_valid=1 and out_ready=0: in_ready=0, no accept, and all outputs and acc are held stable.
  - in_* are don't-care while in_ready=0.
- Counters:
  - Saturate at 2^CNT_WIDTH-1; they do not wrap.
  - When instr_count is saturated, invalid_count still counts independently until it saturates itself.
- No combinational path from in_* to out_*. Only in_ready depends combinationally on out_ready.

Test Plan:
- Reset then stream add 5, add 7, sub 3 with out_ready=1 (WIDTH=8) → out_acc 5, 12, 9 on consecutive cycles; carry 0,0,0; instr_count=3.
- From acc=250, add 10 → out_acc=4, out_carry=1. Then sub 5 → out_acc=255, out_carry=1.
- Opcode 7 with operand 99, then nop → out_invalid=1 on the first beat, acc unchanged; err_sticky=1 and invalid_count=1, both persisting through the nop beat.
- Hold out_ready=0 for 4 cycles after one add → in_ready=0, outputs stable. Then raise out_ready together with in_valid → accept and consume in the same cycle, with no bubble and no lost beat.
- Assert reset_n=0 while out_valid=1 and out_ready=0 → next cycle out_valid=0, acc=0, err_sticky=0, counters=0.
- Force CNT_WIDTH=2, send 5 invalid opcodes → instr_count and invalid_count both stop at 3.
